// File: rtl/bcd_ascii_streamer.sv
// Snapshots a packed BCD value and streams it as ASCII, MSD first, over a valid/ready link.
// Define BCD_LEADING_ZERO_BLANK_EN to print leading zeros as spaces.
module bcd_ascii_streamer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    output logic                  busy,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  done,
    output logic [1:0]            fsm_state
);
    // Handshake: a character transfers on a rising edge where char_valid and
    // char_ready are both high; char_out is held stable until that edge.

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   snap_q, snap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         idx_dec;
    logic [7:0]            char_q, char_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [3:0]            top_digit;
    logic [3:0]            next_digit;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic                  blank_q, blank_d;
`endif

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
    endfunction

    assign idx_dec    = idx_q - 1'b1;
    assign top_digit  = bcd_in[4*DIGITS-1 -: 4];
    assign next_digit = snap_q[{idx_dec, 2'b00} +: 4];

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        char_d  = char_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    // The first character is registered straight from bcd_in so it
                    // is valid in the cycle right after the load edge.
                    snap_d  = bcd_in;
                    idx_d   = LAST;
                    char_d  = to_ascii(top_digit);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                    blank_d = (top_digit == 4'd0);
                    if (top_digit == 4'd0 && LAST != '0) char_d = 8'h20;
`endif
                end
            end
            SEND: begin
                if (valid_q && char_ready) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_dec;
                        char_d = to_ascii(next_digit);
`ifdef BCD_LEADING_ZERO_BLANK_EN
                        // blank_q already reflects every digit printed so far.
                        blank_d = blank_q && (next_digit == 4'd0);
                        if (blank_q && next_digit == 4'd0 && idx_dec != '0) char_d = 8'h20;
`endif
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            blank_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign done       = done_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Directed bench for bcd_ascii_streamer (DIGITS=4); expectations follow
// BCD_LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bcd_ascii_streamer;
    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        load;
    logic        busy;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        done;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    bcd_ascii_streamer #(.DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load       (load),
        .busy       (busy),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: loads value, then runs the stream (cycle 1 = first cycle after
    // the load edge). Returns accepted chars packed first-char-in-MSB, the
    // cycle where done was seen (-1 on timeout) and stall-hold violations.
    task automatic run_stream(input logic [15:0] value, input bit alt_ready,
                              input bit hold_load, output logic [31:0] chars,
                              output int done_cycle, output int hold_errs);
        int n;
        bit stalled;
        logic [7:0] held;
        chars = '0; done_cycle = -1; hold_errs = 0; n = 0; stalled = 0; held = 8'h00;
        bcd_in = value;
        load   = 1'b1;
        tick();
        load   = hold_load;
        bcd_in = hold_load ? 16'h9999 : 16'hFFFF;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            char_ready = alt_ready ? ((cyc % 2) == 0) : 1'b1;
            if (stalled && char_out !== held) hold_errs++;
            stalled = 0;
            if (done) begin
                done_cycle = cyc;
                break;
            end
            if (char_valid) begin
                if (char_ready) begin
                    if (n < 4) chars[8*(3-n) +: 8] = char_out;
                    n++;
                end else begin
                    stalled = 1;
                    held    = char_out;
                end
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0000; char_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        checks++; if (char_out !== 8'h00) begin errors++; $display("FAIL reset_char got=%h exp=00", char_out); end
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", char_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_reset_mid_stream();
        logic [31:0] chars; int dc; int he;
        bcd_in = 16'h1234; load = 1'b1; char_ready = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (char_out !== 8'h31 || char_valid !== 1'b1) begin errors++; $display("FAIL mid_first got=%h/%b exp=31/1", char_out, char_valid); end
        tick();
        char_ready = 1'b0;
        checks++; if (char_out !== 8'h32) begin errors++; $display("FAIL mid_second got=%h exp=32", char_out); end
        tick();
        checks++; if (char_out !== 8'h32 || busy !== 1'b1) begin errors++; $display("FAIL mid_stall got=%h/%b exp=32/1", char_out, busy); end
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if ({char_out, char_valid, busy, done} !== 11'd0 || fsm_state !== 2'd0)
            begin errors++; $display("FAIL mid_reset got=%h,%b,%b,%b,st%0d exp=00,0,0,0,st0", char_out, char_valid, busy, done, fsm_state); end
        char_ready = 1'b1;
        repeat (3) tick();
        checks++; if (char_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_resume got=%b/%b exp=0/0", char_valid, busy); end
        run_stream(16'h5678, 1'b0, 1'b0, chars, dc, he);
        checks++; if (chars !== 32'h35363738) begin errors++; $display("FAIL mid_restart got=%h exp=35363738", chars); end
        tick();
    endtask

    task automatic test_full_rate();
        logic [31:0] chars; int dc; int he;
        run_stream(16'h1234, 1'b0, 1'b0, chars, dc, he);
        checks++; if (chars !== 32'h31323334) begin errors++; $display("FAIL full_chars got=%h exp=31323334", chars); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL full_done_cycle got=%0d exp=5", dc); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL full_after got=busy%b/done%b exp=0/0", busy, done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] chars; int dc; int he;
        logic [31:0] exp_chars;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        exp_chars = 32'h20393037;
`else
        exp_chars = 32'h30393037;
`endif
        run_stream(16'h0907, 1'b1, 1'b0, chars, dc, he);
        checks++; if (chars !== exp_chars) begin errors++; $display("FAIL bp_chars got=%h exp=%h", chars, exp_chars); end
        checks++; if (dc !== 9) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=9", dc); end
        checks++; if (he !== 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", he); end
        tick();
    endtask

    task automatic test_all_zero();
        logic [31:0] chars; int dc; int he;
        logic [31:0] exp_chars;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        exp_chars = 32'h20202030;
`else
        exp_chars = 32'h30303030;
`endif
        run_stream(16'h0000, 1'b0, 1'b0, chars, dc, he);
        checks++; if (chars !== exp_chars) begin errors++; $display("FAIL zero_chars got=%h exp=%h", chars, exp_chars); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=5", dc); end
        tick();
    endtask

    task automatic test_invalid_digit();
        logic [31:0] chars; int dc; int he;
        logic [31:0] exp_chars;
        run_stream(16'h12A4, 1'b0, 1'b0, chars, dc, he);
        checks++; if (chars !== 32'h31323F34) begin errors++; $display("FAIL inv_chars got=%h exp=31323F34", chars); end
        tick();
`ifdef BCD_LEADING_ZERO_BLANK_EN
        exp_chars = 32'h203F3030;
`else
        exp_chars = 32'h303F3030;
`endif
        run_stream(16'h0A00, 1'b0, 1'b0, chars, dc, he);
        checks++; if (chars !== exp_chars) begin errors++; $display("FAIL inv_blank_chars got=%h exp=%h", chars, exp_chars); end
        tick();
    endtask

    task automatic test_load_while_busy();
        logic [31:0] chars; int dc; int he;
        bit seen_done;
        run_stream(16'h1234, 1'b0, 1'b1, chars, dc, he);
        checks++; if (chars !== 32'h31323334) begin errors++; $display("FAIL busy_load_chars got=%h exp=31323334", chars); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL busy_load_done got=%0d exp=5", dc); end
        // load held high into the following IDLE cycle must be taken
        load = 1'b1; bcd_in = 16'h9999;
        tick();
        checks++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin errors++; $display("FAIL busy_load_idle got=%b/st%0d exp=0/st0", busy, fsm_state); end
        tick();
        load = 1'b0;
        checks++; if (char_valid !== 1'b1 || char_out !== 8'h39 || busy !== 1'b1)
            begin errors++; $display("FAIL busy_load_accept got=%b/%h/%b exp=1/39/1", char_valid, char_out, busy); end
        char_ready = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen_done = 1; break; end
            tick();
        end
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL busy_load_drain got=%b exp=1", seen_done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_full_rate();
        test_backpressure();
        test_all_zero();
        test_invalid_digit();
        test_load_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
